// File: rtl/pc_fetch_sequencer.sv
//------------------------------------------------------------------------------
// pc_fetch_sequencer: fetch-stage PC sequencer (sequential/branch/exception, miss hold).
// Optional exception vector: define PC_EXC_VECTOR_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_sequencer #(
  parameter int                WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(64'h18)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Hit,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
`ifdef PC_EXC_VECTOR_EN
  input  logic             ExcReq,
`endif
  output logic [WIDTH-1:0] Address,
  output logic             Flush,
  output logic             FetchValid,
  output logic [31:0]      MissCount
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_MISS  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] w_addr_nxt;
  logic             r_flush;
  logic             w_flush_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [WIDTH-1:0] r_pend_tgt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;
  logic [31:0]      r_miss_cnt;
  logic [31:0]      w_miss_cnt_nxt;
  logic [WIDTH-1:0] w_seq_addr;
  logic [WIDTH-1:0] w_branch_tgt;
  logic             w_exc;

`ifdef PC_EXC_VECTOR_EN
  assign w_exc = ExcReq;
`else
  assign w_exc = 1'b0;
`endif

  assign w_seq_addr   = r_addr + WIDTH'(4);
  assign w_branch_tgt = BranchTarget & c_ALIGN_MASK;

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_flush_nxt    = 1'b0;
    w_pend_nxt     = r_pend;
    w_pend_tgt_nxt = r_pend_tgt;

    if (w_exc) begin
      w_addr_nxt  = EXC_VECTOR & c_ALIGN_MASK;
      w_flush_nxt = 1'b1;
      w_pend_nxt  = 1'b0;
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // A live redirect re-probes the cache at the new address instead of missing.
          if (BranchTaken) begin
            w_addr_nxt  = w_branch_tgt;
            w_flush_nxt = 1'b1;
          end else if (Hit) begin
            if (!Stall) begin
              w_addr_nxt = w_seq_addr;
            end
          end else begin
            w_state_nxt = ST_MISS;
          end
        end
        ST_MISS: begin
          if (Hit) begin
            w_state_nxt = ST_FETCH;
            w_pend_nxt  = 1'b0;
            if (BranchTaken) begin
              w_addr_nxt  = w_branch_tgt;
              w_flush_nxt = 1'b1;
            end else if (r_pend) begin
              w_addr_nxt  = r_pend_tgt;
              w_flush_nxt = 1'b1;
            end else if (!Stall) begin
              w_addr_nxt = w_seq_addr;
            end
          end else if (BranchTaken) begin
            w_pend_nxt     = 1'b1;
            w_pend_tgt_nxt = w_branch_tgt;
          end
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  assign w_miss_cnt_nxt = ((r_state == ST_MISS) && (r_miss_cnt != 32'hFFFF_FFFF))
                          ? r_miss_cnt + 32'd1 : r_miss_cnt;

  always_ff @(negedge Clock) begin
    if (Reset) begin
      r_state    <= ST_FETCH;
      r_addr     <= RESET_VECTOR;
      r_flush    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_flush    <= w_flush_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
    end
  end

  assign Address    = r_addr;
  assign Flush      = r_flush;
  assign MissCount  = r_miss_cnt;
  assign FetchValid = (r_state == ST_FETCH) && Hit;

endmodule

`default_nettype wire
